mips32_multicycle_ctrl: RTL and testbench

Parametrised multi-cycle control unit for the MIPS32 SoC. It replaces the single-cycle opcode decoder with a Moore state machine that sequences fetch, decode, execute, memory and write-back over several clocks. It stalls on a memory ready handshake, traps illegal opcodes, and counts retired instructions. It sits between the instruction register's opcode field and the multi-cycle datapath: shared memory, IR, ALU-source muxes, register file and PC.

---
 rtl/mips32_multicycle_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mips32_multicycle_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_multicycle_ctrl.sv
// Multi-cycle Moore control unit for the MIPS32 datapath.
// It sequences FETCH, DECODE, EXEC/MEM and write-back, stalls on the memory
// ready handshake, traps unsupported opcodes and counts retired instructions.
//
// Ports:
//   clk, rst_n           : clock and asynchronous active-low reset
//   opcode               : IR[31:26], sampled into op_q during DECODE
//   mem_ready            : memory completed the current access
//   pc_write/_cond, bne  : PC load controls (unconditional / zero / not zero)
//   iord, mem_read/write : memory address select and strobes
//   ir_write             : IR load enable
//   reg_dst, mem_to_reg, reg_write : register-file write controls
//   alu_src_a/b, alu_op  : ALU operand and operation selects
//   pc_source            : PC next-value select
//   state                : current state code (debug)
//   illegal, instr_done  : one-cycle trap / instruction-complete pulses
//   retired              : count of instr_done pulses, wraps silently
module mips32_multicycle_ctrl #(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter bit          IMM_EN        = 1'b1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             bne,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADDR  = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXEC     = 4'd7,
    S_RWB      = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] retired_q;
  logic             rdy;

  assign rdy     = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state   = state_q;
  assign retired = retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      if (instr_done) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    bne           = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal       = 1'b0;
    instr_done    = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR and PC load only on the completing cycle so a stall leaves them untouched.
        if (rdy) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        op_d      = opcode;
        case (opcode)
          OP_RTYPE:      state_d = S_EXEC;
          OP_J:          state_d = S_JUMP;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_LW, OP_SW:  state_d = S_MEMADDR;
          OP_ADDI:       state_d = IMM_EN ? S_ADDI_EX : S_TRAP;
          default:       state_d = S_TRAP;
        endcase
      end
      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op_q == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (rdy) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_source     = 2'b01;
        pc_write_cond = (op_q == OP_BEQ);
        bne           = (op_q == OP_BNE);
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        illegal    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips32_multicycle_ctrl.sv
// Scoreboard bench for mips32_multicycle_ctrl.
// Channel 0: handshake on, addi supported, 3-bit counter.
// Channel 1: handshake off, addi traps, 2-bit counter.
// The channels run one after the other; the idle one is held in reset.
module tb_mips32_multicycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn [2];
  logic [5:0] opc  [2];
  logic       mrdy [2];

  logic       pcw_w [2], pcc_w [2], bne_w [2], iord_w [2], mr_w [2], mw_w [2];
  logic       irw_w [2], rd_w [2], m2r_w [2], rw_w [2], asa_w [2], il_w [2], id_w [2];
  logic [1:0] asb_w [2], aop_w [2], ps_w [2];
  logic [3:0] st_w  [2];
  logic [2:0] ret0;
  logic [1:0] ret1;

  mips32_multicycle_ctrl #(.MEM_HANDSHAKE(1'b1), .IMM_EN(1'b1), .CNT_W(3)) u0 (
    .clk(clk), .rst_n(rstn[0]), .opcode(opc[0]), .mem_ready(mrdy[0]),
    .pc_write(pcw_w[0]), .pc_write_cond(pcc_w[0]), .bne(bne_w[0]), .iord(iord_w[0]),
    .mem_read(mr_w[0]), .mem_write(mw_w[0]), .ir_write(irw_w[0]), .reg_dst(rd_w[0]),
    .mem_to_reg(m2r_w[0]), .reg_write(rw_w[0]), .alu_src_a(asa_w[0]), .alu_src_b(asb_w[0]),
    .alu_op(aop_w[0]), .pc_source(ps_w[0]), .state(st_w[0]), .illegal(il_w[0]),
    .instr_done(id_w[0]), .retired(ret0));

  mips32_multicycle_ctrl #(.MEM_HANDSHAKE(1'b0), .IMM_EN(1'b0), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rstn[1]), .opcode(opc[1]), .mem_ready(mrdy[1]),
    .pc_write(pcw_w[1]), .pc_write_cond(pcc_w[1]), .bne(bne_w[1]), .iord(iord_w[1]),
    .mem_read(mr_w[1]), .mem_write(mw_w[1]), .ir_write(irw_w[1]), .reg_dst(rd_w[1]),
    .mem_to_reg(m2r_w[1]), .reg_write(rw_w[1]), .alu_src_a(asa_w[1]), .alu_src_b(asb_w[1]),
    .alu_op(aop_w[1]), .pc_source(ps_w[1]), .state(st_w[1]), .illegal(il_w[1]),
    .instr_done(id_w[1]), .retired(ret1));

  // One expected instruction: its state trace (4 bits per cycle), effective
  // ready per cycle, and the retired count that must be visible throughout.
  typedef struct {
    int         ch;
    logic [5:0] op;
    int         len;
    logic [63:0] tr;
    logic [15:0] rdy;
    int         retb;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   rcnt [2];
  int   kk = 0;

  function automatic bit hs(input int c);   return (c == 0); endfunction
  function automatic bit immx(input int c); return (c == 0); endfunction
  function automatic int cmask(input int c); return (c == 0) ? 7 : 3; endfunction

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s ch%0d t=%0t actual=%0h required=%0h", nm, c, $time, act, expv);
    end
  endtask

  // Control outputs each state must present, straight from the state table.
  function automatic logic [18:0] exp_out(input logic [3:0] s, input logic r, input logic [5:0] op);
    logic pcw, pcc, bn, io, mr, mw, irw, rd, m2r, rw, asa, il, id;
    logic [1:0] asb, aop, psrc;
    {pcw, pcc, bn, io, mr, mw, irw, rd, m2r, rw, asa, il, id} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (s)
      4'd1:  begin mr = 1'b1; asb = 2'b01; irw = r; pcw = r; end
      4'd2:  asb = 2'b11;
      4'd3:  begin asa = 1'b1; asb = 2'b10; end
      4'd4:  begin mr = 1'b1; io = 1'b1; end
      4'd5:  begin rw = 1'b1; m2r = 1'b1; id = 1'b1; end
      4'd6:  begin mw = 1'b1; io = 1'b1; id = r; end
      4'd7:  begin asa = 1'b1; aop = 2'b10; end
      4'd8:  begin rw = 1'b1; rd = 1'b1; id = 1'b1; end
      4'd9:  begin asa = 1'b1; aop = 2'b01; psrc = 2'b01; pcc = (op == 6'd4); bn = (op == 6'd5); id = 1'b1; end
      4'd10: begin pcw = 1'b1; psrc = 2'b10; id = 1'b1; end
      4'd11: begin asa = 1'b1; asb = 2'b10; end
      4'd12: begin rw = 1'b1; id = 1'b1; end
      4'd13: begin il = 1'b1; id = 1'b1; end
      default: ;
    endcase
    return {pcw, pcc, bn, io, mr, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, il, id};
  endfunction

  // kind: 0 = ready is don't-care, 1 = stall cycle, 2 = completing cycle
  function automatic void addst(inout exp_t e, inout logic [15:0] dv, input int c,
                                input logic [3:0] s, input int kind);
    logic d;
    d = (kind == 1) ? 1'b0 : (kind == 2) ? 1'b1 : 1'($urandom_range(0, 1));
    e.tr[4*e.len +: 4] = s;
    e.rdy[e.len]       = hs(c) ? d : 1'b1;
    dv[e.len]          = d;
    e.len++;
  endfunction

  // Issue one instruction: derive its cycle-by-cycle path from the opcode
  // class and stall counts, queue it, then drive the inputs for every cycle.
  // abort_at >= 0 asserts reset in that cycle and checks the async clear.
  task automatic issue(input int c, input logic [5:0] op, input int f_in, input int m_in,
                       input bit first, input int abort_at);
    exp_t e;
    logic [15:0] dv;
    int f, m;
    f = hs(c) ? f_in : 0;
    m = hs(c) ? m_in : 0;
    e.ch = c; e.op = op; e.len = 0; e.tr = '0; e.rdy = '0; e.retb = rcnt[c]; dv = '0;
    if (first) addst(e, dv, c, 4'd0, 0);
    repeat (f) addst(e, dv, c, 4'd1, 1);
    addst(e, dv, c, 4'd1, 2);
    addst(e, dv, c, 4'd2, 0);
    if (op == 6'd0) begin
      addst(e, dv, c, 4'd7, 0); addst(e, dv, c, 4'd8, 0);
    end else if (op == 6'd2) begin
      addst(e, dv, c, 4'd10, 0);
    end else if (op == 6'd4 || op == 6'd5) begin
      addst(e, dv, c, 4'd9, 0);
    end else if (op == 6'd35) begin
      addst(e, dv, c, 4'd3, 0);
      repeat (m) addst(e, dv, c, 4'd4, 1);
      addst(e, dv, c, 4'd4, 2);
      addst(e, dv, c, 4'd5, 0);
    end else if (op == 6'd43) begin
      addst(e, dv, c, 4'd3, 0);
      repeat (m) addst(e, dv, c, 4'd6, 1);
      addst(e, dv, c, 4'd6, 2);
    end else if (op == 6'd8 && immx(c)) begin
      addst(e, dv, c, 4'd11, 0); addst(e, dv, c, 4'd12, 0);
    end else begin
      addst(e, dv, c, 4'd13, 0);
    end
    for (int i = 0; i < e.len; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        sbq.push_back(e);
        if (abort_at < 0) rcnt[c] = (rcnt[c] + 1) & cmask(c);
      end
      opc[c]  = (e.tr[4*i +: 4] == 4'd2) ? op : 6'($urandom);
      mrdy[c] = dv[i];
      if (i == 0 && first) rstn[c] = 1'b1;
      if (i == abort_at) begin
        #2 rstn[c] = 1'b0;
        #1;
        chk("rst_state", c, 32'(st_w[c]), 32'd0);
        chk("rst_memread", c, 32'(mr_w[c]), 32'd0);
        chk("rst_iord", c, 32'(iord_w[c]), 32'd0);
        chk("rst_retired", c, (c == 0) ? 32'(ret0) : 32'(ret1), 32'd0);
        rcnt[c] = 0;
        return;
      end
    end
  endtask

  task automatic rnd_instr(input int c);
    logic [5:0] ops [7];
    int idx;
    logic [5:0] op;
    ops[0] = 6'd0; ops[1] = 6'd2; ops[2] = 6'd4; ops[3] = 6'd5;
    ops[4] = 6'd35; ops[5] = 6'd43; ops[6] = 6'd8;
    idx = $urandom_range(0, 7);
    op  = (idx == 7) ? 6'($urandom) : ops[idx];
    issue(c, op, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0, -1);
  endtask

  // Monitor: every cycle of the active channel is compared to the head of
  // the scoreboard; the entry retires on instr_done or when its trace ends.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn[0] && !rstn[1]) begin
        sbq.delete();
        kk = 0;
      end else begin
        automatic int c = rstn[0] ? 0 : 1;
        if (sbq.size() == 0) begin
          chk("no_expected", c, 32'd1, 32'd0);
        end else begin
          automatic exp_t e = sbq[0];
          automatic logic [3:0] es = e.tr[4*kk +: 4];
          automatic logic [18:0] ov = {pcw_w[c], pcc_w[c], bne_w[c], iord_w[c], mr_w[c],
                                       mw_w[c], irw_w[c], rd_w[c], m2r_w[c], rw_w[c], asa_w[c],
                                       asb_w[c], aop_w[c], ps_w[c], il_w[c], id_w[c]};
          chk("state", c, 32'(st_w[c]), 32'(es));
          chk("outputs", c, 32'(ov), 32'(exp_out(es, e.rdy[kk], e.op)));
          chk("retired", c, (c == 0) ? 32'(ret0) : 32'(ret1), 32'(e.retb));
          kk++;
          if (id_w[c] || kk >= e.len) begin
            chk("instr_length", c, 32'(kk), 32'(e.len));
            void'(sbq.pop_front());
            kk = 0;
          end
        end
      end
    end
  end

  initial begin
    rstn[0] = 1'b0; rstn[1] = 1'b0;
    opc[0] = '0; opc[1] = '0; mrdy[0] = 1'b0; mrdy[1] = 1'b0;
    rcnt[0] = 0; rcnt[1] = 0;
    repeat (3) @(posedge clk);

    // Channel 0: R-type then sw, stalled lw, branches, addi, illegal, reset mid-lw.
    issue(0, 6'd0,  0, 0, 1'b1, -1);
    issue(0, 6'd43, 0, 0, 1'b0, -1);
    issue(0, 6'd35, 0, 3, 1'b0, -1);
    issue(0, 6'd4,  1, 0, 1'b0, -1);
    issue(0, 6'd5,  0, 0, 1'b0, -1);
    issue(0, 6'd8,  0, 0, 1'b0, -1);
    issue(0, 6'd63, 0, 0, 1'b0, -1);
    issue(0, 6'd43, 2, 2, 1'b0, -1);
    issue(0, 6'd35, 0, 3, 1'b0, 4);
    issue(0, 6'd0,  0, 0, 1'b1, -1);
    repeat (40) rnd_instr(0);
    @(posedge clk); #1 rstn[0] = 1'b0;

    // Channel 1: addi traps, illegal 63, five jumps wrap the 2-bit counter.
    issue(1, 6'd8,  0, 0, 1'b1, -1);
    issue(1, 6'd63, 0, 0, 1'b0, -1);
    repeat (5) issue(1, 6'd2, 0, 0, 1'b0, -1);
    issue(1, 6'd35, 0, 0, 1'b0, -1);
    repeat (25) rnd_instr(1);
    @(posedge clk); #1 rstn[1] = 1'b0;
    @(negedge clk);
    #1 chk("drain", 1, 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
